// File: rtl/obstacle_speed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : obstacle_speed_ctrl
//  Purpose  : Sets how many pixels the obstacles advance on each 60 Hz game
//             tick. A speed level rises each time the hundreds digit of the
//             BCD score changes, saturating at MAX_LEVEL. A 1/16-pixel
//             fractional accumulator turns the per-level increment into a
//             smooth whole-pixel advance count.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             i_game_tick          - one-cycle 60 Hz tick pulse
//             i_game_start_pulse   - one-cycle pulse, new game begins
//             i_game_frozen        - high while game over / paused
//             i_score[15:0]        - BCD score, [15:12] thousands
//             o_move_valid         - one-cycle pulse, o_move_px valid
//             o_move_px[1:0]       - pixels to advance this tick
//             o_level              - current speed level
//             o_running            - high in the RUN state
//  Revision : 1.0 - initial release
// ============================================================================
module obstacle_speed_ctrl #(
  parameter int LEVEL_BITS = 3,
  parameter int MAX_LEVEL  = 7,
  parameter int BASE_INC   = 16,
  parameter int LEVEL_INC  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_game_tick,
  input  logic                  i_game_start_pulse,
  input  logic                  i_game_frozen,
  input  logic [15:0]           i_score,
  output logic                  o_move_valid,
  output logic [1:0]            o_move_px,
  output logic [LEVEL_BITS-1:0] o_level,
  output logic                  o_running
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  logic [1:0]            state;
  logic [LEVEL_BITS-1:0] level;
  logic [3:0]            frac;
  logic [3:0]            prev_digit;
  logic                  move_valid;
  logic [1:0]            move_px;
  logic                  running;

  logic [5:0]            inc;
  logic [5:0]            sum;
  logic                  level_up;

  // Tens and units digits do not affect speed.
  logic                  unused_score_low;
  assign unused_score_low = ^i_score[7:0];

  // Increment uses the level register as it stands, so a level-up in the
  // same cycle as a tick only affects later ticks.
  assign inc = 6'(BASE_INC) + 6'(LEVEL_INC) * 6'(level);
  assign sum = {2'b00, frac} + inc;

  // Any change of the hundreds digit is a level-up, except when the upper
  // two digits are zero: that is a score cleared to 0000, not progress.
  // The 0999 -> 1000 rollover still counts because the thousands digit is set.
  assign level_up = (i_score[11:8] != prev_digit) &&
                    (i_score[15:8] != 8'h00) &&
                    (level != LEVEL_BITS'(MAX_LEVEL));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      level      <= '0;
      frac       <= '0;
      prev_digit <= '0;
      move_valid <= 1'b0;
      move_px    <= '0;
      running    <= 1'b0;
    end else begin
      prev_digit <= i_score[11:8];
      move_valid <= 1'b0;
      if (i_game_start_pulse) begin
        // Start beats freeze and swallows any tick in the same cycle.
        state   <= ST_RUN;
        running <= 1'b1;
        level   <= '0;
        frac    <= '0;
      end else if (state == ST_RUN) begin
        if (i_game_frozen) begin
          state   <= ST_FROZEN;
          running <= 1'b0;
        end else if (i_game_tick) begin
          move_valid <= 1'b1;
          move_px    <= sum[5:4];
          frac       <= sum[3:0];
        end
        if (level_up) begin
          level <= level + 1'b1;
        end
      end
      // IDLE and FROZEN hold everything until a start pulse.
    end
  end

  assign o_move_valid = move_valid;
  assign o_move_px    = move_px;
  assign o_level      = level;
  assign o_running    = running;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_speed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obstacle_speed_ctrl
//  Purpose  : Self-checking bench for obstacle_speed_ctrl. A behavioural
//             model tracks game mode, level and sub-pixel position with plain
//             integer arithmetic; directed scenarios also check the literal
//             pixel sequences expected for each level.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_obstacle_speed_ctrl;

  localparam int LB = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          game_tick = 1'b0;
  logic          game_start = 1'b0;
  logic          game_frozen = 1'b0;
  logic [15:0]   score = 16'h0000;
  logic          move_valid;
  logic [1:0]    move_px;
  logic [LB-1:0] level;
  logic          running;

  int checks = 0;
  int fails  = 0;

  // Model: mode 0 = idle, 1 = run, 2 = frozen
  int m_mode, m_level, m_frac, m_prev;
  logic          exp_valid;
  logic [1:0]    exp_px;
  logic [LB-1:0] exp_level;
  logic          exp_running;

  obstacle_speed_ctrl #(
    .LEVEL_BITS(LB), .MAX_LEVEL(7), .BASE_INC(16), .LEVEL_INC(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_game_tick(game_tick), .i_game_start_pulse(game_start),
    .i_game_frozen(game_frozen), .i_score(score),
    .o_move_valid(move_valid), .o_move_px(move_px),
    .o_level(level), .o_running(running)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_level = 0; m_frac = 0; m_prev = 0;
    exp_valid = 1'b0; exp_px = 2'd0; exp_level = '0; exp_running = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic drive(input logic tick, input logic start, input logic frz,
                       input logic [15:0] sc);
    int digit, tot;
    bit changed;
    digit   = int'(sc[11:8]);
    changed = (digit != m_prev) && (sc[15:8] != 8'h00);
    exp_valid = 1'b0;
    if (start) begin
      m_mode = 1; m_level = 0; m_frac = 0;
    end else if (m_mode == 1) begin
      if (frz) m_mode = 2;
      else if (tick) begin
        tot       = m_frac + 16 + 4 * m_level;
        exp_px    = 2'(tot / 16);
        m_frac    = tot % 16;
        exp_valid = 1'b1;
      end
      if (changed && m_level < 7) m_level = m_level + 1;
    end
    m_prev      = digit;
    exp_level   = LB'(m_level);
    exp_running = (m_mode == 1);
    game_tick = tick; game_start = start; game_frozen = frz; score = sc;
    @(posedge clk); #1;
    game_tick = 1'b0; game_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; game_tick = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; game_tick = 1'b0; model_reset();
    checks++; if (move_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", move_valid); end
    checks++; if (level !== '0) begin fails++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (running !== 1'b0) begin fails++; $display("FAIL reset_running: got %0b expected 0", running); end
    checks++; if (move_px !== 2'd0) begin fails++; $display("FAIL reset_px: got %0d expected 0", move_px); end
    // Mid-game reset with a tick in flight
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0100);
    drive(1'b0, 1'b0, 1'b0, 16'h0200);
    game_tick = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; game_tick = 1'b0; score = 16'h0000; model_reset();
    checks++; if (move_valid !== 1'b0 || level !== '0 || running !== 1'b0 || move_px !== 2'd0) begin
      fails++; $display("FAIL midrun_reset: got v=%0b l=%0d r=%0b px=%0d expected all 0", move_valid, level, running, move_px);
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    checks++; if (move_valid !== 1'b0) begin fails++; $display("FAIL idle_tick: got valid %0b expected 0", move_valid); end
  endtask

  task automatic test_level0();
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    checks++; if (move_valid !== 1'b0 || running !== 1'b1) begin
      fails++; $display("FAIL start_tick: got v=%0b r=%0b expected v=0 r=1", move_valid, running);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0000);
      checks++; if (move_valid !== 1'b1 || move_px !== 2'd1) begin
        fails++; $display("FAIL level0_tick%0d: got v=%0b px=%0d expected v=1 px=1", i, move_valid, move_px);
      end
      for (int j = 0; j < 99; j++) drive(1'b0, 1'b0, 1'b0, 16'h0000);
      checks++; if (move_valid !== 1'b0) begin fails++; $display("FAIL level0_gap%0d: got valid %0b expected 0", i, move_valid); end
    end
  endtask

  task automatic test_level_up();
    logic [1:0] want [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
    drive(1'b0, 1'b1, 1'b0, 16'h0099);
    drive(1'b0, 1'b0, 1'b0, 16'h0100);
    checks++; if (level !== 3'd1) begin fails++; $display("FAIL levelup_level: got %0d expected 1", level); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0100);
      checks++; if (move_valid !== 1'b1 || move_px !== want[i] || move_px !== exp_px) begin
        fails++; $display("FAIL levelup_px%0d: got v=%0b px=%0d expected px=%0d", i, move_valid, move_px, want[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] want [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int d = 1; d <= 9; d++) drive(1'b0, 1'b0, 1'b0, to_bcd(d * 100));
    drive(1'b0, 1'b0, 1'b0, 16'h1000);
    checks++; if (level !== 3'd7 || level !== exp_level) begin fails++; $display("FAIL sat_level: got %0d expected 7", level); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h1000);
      checks++; if (move_valid !== 1'b1 || move_px !== want[i]) begin
        fails++; $display("FAIL sat_px%0d: got v=%0b px=%0d expected px=%0d", i, move_valid, move_px, want[i]);
      end
    end
  endtask

  task automatic test_freeze_restart();
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int d = 1; d <= 3; d++) drive(1'b0, 1'b0, 1'b0, to_bcd(d * 100));
    drive(1'b1, 1'b0, 1'b1, 16'h0300);
    checks++; if (move_valid !== 1'b0 || running !== 1'b0) begin
      fails++; $display("FAIL freeze_tick: got v=%0b r=%0b expected v=0 r=0", move_valid, running);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, (i < 3), 16'h0300);
      checks++; if (move_valid !== 1'b0 || level !== 3'd3 || running !== 1'b0) begin
        fails++; $display("FAIL frozen_hold%0d: got v=%0b l=%0d r=%0b expected v=0 l=3 r=0", i, move_valid, level, running);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 16'h0000);
    checks++; if (move_valid !== 1'b0 || level !== '0 || running !== 1'b1) begin
      fails++; $display("FAIL restart: got v=%0b l=%0d r=%0b expected v=0 l=0 r=1", move_valid, level, running);
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    checks++; if (move_valid !== 1'b1 || move_px !== 2'd1) begin
      fails++; $display("FAIL restart_px: got v=%0b px=%0d expected v=1 px=1", move_valid, move_px);
    end
  endtask

  task automatic test_score_guard();
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0100);
    drive(1'b0, 1'b0, 1'b0, 16'h0200);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    checks++; if (level !== 3'd2) begin fails++; $display("FAIL score_guard: got level %0d expected 2", level); end
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0200);
      if (move_valid === 1'b1) seen++;
      checks++; if (move_px !== exp_px) begin
        fails++; $display("FAIL b2b_px%0d: got %0d expected %0d", i, move_px, exp_px);
      end
    end
    checks++; if (seen != 20) begin fails++; $display("FAIL b2b_count: got %0d valids expected 20", seen); end
  endtask

  task automatic test_random();
    int sv;
    logic t, s, f;
    sv = 0; f = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) sv = sv + int'($urandom_range(0, 150));
      if ($urandom_range(0, 299) == 0) sv = 0;
      if (sv > 9999) sv = 9999;
      t = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 59) == 0) f = ~f;
      drive(t, s, f, to_bcd(sv));
      checks++; if (move_valid !== exp_valid || level !== exp_level || running !== exp_running ||
                    (exp_valid && move_px !== exp_px)) begin
        fails++;
        $display("FAIL rand_cycle%0d: got v=%0b px=%0d l=%0d r=%0b expected v=%0b px=%0d l=%0d r=%0b",
                 i, move_valid, move_px, level, running, exp_valid, exp_px, exp_level, exp_running);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_level0();
    test_level_up();
    test_saturation();
    test_freeze_restart();
    test_score_guard();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
